// File: rtl/stopwatch_ctrl_if.sv
// Control and readout bundle for stopwatch_ctrl: command pulses in, registered
// count, lap and status outputs back.
interface stopwatch_ctrl_if #(
   parameter int unsigned W = 16
);
   logic         start;
   logic         stop;
   logic         clear;
   logic         lap;
   logic [W-1:0] count;
   logic [W-1:0] lap_count;
   logic         lap_valid;
   logic         running;
   logic         done;
   logic         tick;
   logic         wrap;

   modport master (
      output start, stop, clear, lap,
      input  count, lap_count, lap_valid, running, done, tick, wrap
   );

   modport slave (
      input  start, stop, clear, lap,
      output count, lap_count, lap_valid, running, done, tick, wrap
   );
endinterface

// File: rtl/stopwatch_ctrl.sv
// Run/pause/stop controller with a prescaled event counter, lap capture and
// terminal-count handling (saturate into DONE or roll over).
module stopwatch_ctrl #(
   parameter int unsigned W         = 16,
   parameter int unsigned PRESCALE  = 1,
   parameter int unsigned MAX_COUNT = 2**16 - 1,
   parameter bit          WRAP      = 1'b0
) (
   input logic             clk,
   input logic             rst,
   stopwatch_ctrl_if.slave bus
);

   localparam int unsigned    PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
   localparam logic [W-1:0]   MAX      = W'(MAX_COUNT);
   localparam logic [W-1:0]   ONE      = W'(1);

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      PAUSE,
      DONE
   } state_t;

   state_t        state;
   logic [PW-1:0] presc;

   logic resume;
   logic terminal;
   logic at_max;
   logic last_inc;
   logic lap_ok;

   // stop outranks start, so a simultaneous pair never (re)starts the counter
   assign resume   = bus.start & ~bus.stop;
   assign terminal = (presc == PRE_LAST);
   assign at_max   = (bus.count == MAX);
   assign last_inc = (bus.count == MAX - ONE);
   assign lap_ok   = bus.lap & ((state == RUN) | (state == PAUSE));

   // NOTE: every register here uses <= so all updates see pre-edge values;
   // the lap capture below relies on that to record the pre-increment count.
   always_ff @(posedge clk) begin
      if (rst || bus.clear) begin
         state         <= IDLE;
         presc         <= '0;
         bus.count     <= '0;
         bus.lap_count <= '0;
         bus.lap_valid <= 1'b0;
         bus.running   <= 1'b0;
         bus.done      <= 1'b0;
         bus.tick      <= 1'b0;
         bus.wrap      <= 1'b0;
      end else begin
         bus.tick      <= 1'b0;
         bus.wrap      <= 1'b0;
         bus.lap_valid <= lap_ok;
         if (lap_ok) begin
            bus.lap_count <= bus.count;
         end

         unique case (state)
            IDLE, PAUSE: begin
               if (resume) begin
                  state       <= RUN;
                  bus.running <= 1'b1;
               end
            end

            RUN: begin
               if (bus.stop) begin
                  state       <= PAUSE;
                  bus.running <= 1'b0;
               end else if (!terminal) begin
                  presc <= presc + PW'(1);
               end else begin
                  presc <= '0;
                  if (!at_max) begin
                     bus.count <= bus.count + ONE;
                     bus.tick  <= 1'b1;
                     // Saturating mode: the edge that reaches MAX also parks the FSM.
                     if (!WRAP && last_inc) begin
                        state       <= DONE;
                        bus.running <= 1'b0;
                        bus.done    <= 1'b1;
                     end
                  end else if (WRAP) begin
                     bus.count <= '0;
                     bus.tick  <= 1'b1;
                     bus.wrap  <= 1'b1;
                  end else begin
                     state       <= DONE;
                     bus.running <= 1'b0;
                     bus.done    <= 1'b1;
                  end
               end
            end

            DONE: begin
               state <= DONE;
            end

            default: begin
               state       <= IDLE;
               bus.running <= 1'b0;
               bus.done    <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Scoreboard bench: two instances (saturating and wrapping) share one command
// stream and are checked against an elapsed-run-cycle reference model.
module tb_stopwatch_ctrl;

   localparam int PRE  = 4;
   localparam int MAXC = 9;

   localparam int M_IDLE  = 0;
   localparam int M_RUN   = 1;
   localparam int M_PAUSE = 2;
   localparam int M_DONE  = 3;

   typedef struct packed {
      logic [7:0] count;
      logic [7:0] lap_count;
      logic       lap_valid;
      logic       running;
      logic       done;
      logic       tick;
      logic       wrap;
   } obs_t;

   logic clk;
   logic rst;

   stopwatch_ctrl_if #(.W(8)) ifc0 ();
   stopwatch_ctrl_if #(.W(8)) ifc1 ();

   stopwatch_ctrl #(.W(8), .PRESCALE(PRE), .MAX_COUNT(MAXC), .WRAP(1'b0)) dut0 (
      .clk (clk),
      .rst (rst),
      .bus (ifc0)
   );

   stopwatch_ctrl #(.W(8), .PRESCALE(PRE), .MAX_COUNT(MAXC), .WRAP(1'b1)) dut1 (
      .clk (clk),
      .rst (rst),
      .bus (ifc1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   obs_t       exp_q0[$];
   obs_t       exp_q1[$];
   logic [7:0] lap_q0[$];
   logic [7:0] lap_q1[$];

   // Reference model: count is derived from the number of productive RUN cycles.
   int         m_mode[2];
   int         m_runc[2];
   logic [7:0] m_lap[2];

   function automatic int count_of(input int k);
      int incs;
      incs = m_runc[k] / PRE;
      if (k == 1) return incs % (MAXC + 1);
      return (incs > MAXC) ? MAXC : incs;
   endfunction

   task automatic model_step(input int k, input bit r, st, sp, cl, lp, output obs_t e);
      int incs;
      e = '0;
      if (r || cl) begin
         m_mode[k] = M_IDLE;
         m_runc[k] = 0;
         m_lap[k]  = '0;
      end else begin
         if (lp && (m_mode[k] == M_RUN || m_mode[k] == M_PAUSE)) begin
            m_lap[k]    = 8'(count_of(k));
            e.lap_valid = 1'b1;
         end
         case (m_mode[k])
            M_IDLE, M_PAUSE: if (st && !sp) m_mode[k] = M_RUN;
            M_RUN: begin
               if (sp) begin
                  m_mode[k] = M_PAUSE;
               end else begin
                  m_runc[k] = m_runc[k] + 1;
                  if (m_runc[k] % PRE == 0) begin
                     e.tick = 1'b1;
                     incs   = m_runc[k] / PRE;
                     if (k == 1) e.wrap = (incs % (MAXC + 1) == 0);
                     else if (incs >= MAXC) m_mode[k] = M_DONE;
                  end
               end
            end
            default: ;
         endcase
      end
      e.count     = 8'(count_of(k));
      e.lap_count = m_lap[k];
      e.running   = (m_mode[k] == M_RUN);
      e.done      = (m_mode[k] == M_DONE);
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s t=%0t got=%h want=%h", name, $time, act, req);
      end
   endtask

   // One clock of stimulus: drive both DUTs, advance the model, queue expectations.
   task automatic cyc(input bit r, st, sp, cl, lp);
      obs_t e0, e1;
      rst        = r;
      ifc0.start = st; ifc0.stop = sp; ifc0.clear = cl; ifc0.lap = lp;
      ifc1.start = st; ifc1.stop = sp; ifc1.clear = cl; ifc1.lap = lp;
      model_step(0, r, st, sp, cl, lp, e0);
      model_step(1, r, st, sp, cl, lp, e1);
      @(posedge clk);
      exp_q0.push_back(e0);
      exp_q1.push_back(e1);
      if (e0.lap_valid) lap_q0.push_back(e0.lap_count);
      if (e1.lap_valid) lap_q1.push_back(e1.lap_count);
      #1;
   endtask

   function automatic obs_t sample0();
      obs_t o;
      o = {ifc0.count, ifc0.lap_count, ifc0.lap_valid, ifc0.running, ifc0.done,
           ifc0.tick, ifc0.wrap};
      return o;
   endfunction

   function automatic obs_t sample1();
      obs_t o;
      o = {ifc1.count, ifc1.lap_count, ifc1.lap_valid, ifc1.running, ifc1.done,
           ifc1.tick, ifc1.wrap};
      return o;
   endfunction

   // Monitors: full output vector every cycle, lap value whenever lap_valid shows.
   always @(negedge clk) begin
      if (exp_q0.size() > 0) check("sat_outputs", 32'(sample0()), 32'(exp_q0.pop_front()));
      if (exp_q1.size() > 0) check("wrap_outputs", 32'(sample1()), 32'(exp_q1.pop_front()));
   end

   always @(negedge clk) begin
      if (ifc0.lap_valid === 1'b1) begin
         if (lap_q0.size() == 0) check("sat_lap_unexpected", 32'(ifc0.lap_count), 32'hffff_ffff);
         else                    check("sat_lap_value", 32'(ifc0.lap_count), 32'(lap_q0.pop_front()));
      end
      if (ifc1.lap_valid === 1'b1) begin
         if (lap_q1.size() == 0) check("wrap_lap_unexpected", 32'(ifc1.lap_count), 32'hffff_ffff);
         else                    check("wrap_lap_value", 32'(ifc1.lap_count), 32'(lap_q1.pop_front()));
      end
   end

   initial begin
      rst = 1'b1;
      ifc0.start = 1'b0; ifc0.stop = 1'b0; ifc0.clear = 1'b0; ifc0.lap = 1'b0;
      ifc1.start = 1'b0; ifc1.stop = 1'b0; ifc1.clear = 1'b0; ifc1.lap = 1'b0;
      @(posedge clk);
      #1;

      repeat (3) cyc(1, 0, 0, 0, 0);
      repeat (2) cyc(0, 1, 1, 0, 0);          // start+stop in IDLE stays IDLE
      cyc(0, 0, 0, 0, 1);                     // lap in IDLE ignored
      cyc(0, 1, 0, 0, 0);                     // start
      repeat (14) cyc(0, 0, 0, 0, 0);         // count reaches 3, prescaler at 2
      cyc(0, 0, 1, 0, 0);                     // pause
      repeat (20) cyc(0, 0, 0, 0, 0);
      cyc(0, 1, 1, 0, 0);                     // stop wins in PAUSE
      cyc(0, 1, 0, 0, 0);                     // resume
      repeat (3) cyc(0, 0, 0, 0, 0);
      repeat (8) cyc(0, 0, 0, 0, 1);          // laps straddle the 4->5 increment
      repeat (30) cyc(0, 0, 0, 0, 0);         // saturate into DONE, wrap on the other DUT
      repeat (10) cyc(0, 1, 1, 0, 1);         // commands ignored in DONE
      cyc(0, 0, 0, 1, 0);                     // clear
      cyc(0, 1, 0, 0, 0);
      repeat (24) cyc(0, 1, 0, 0, 0);         // start held in RUN
      cyc(1, 1, 0, 0, 0);                     // reset mid-run with start held
      repeat (3) cyc(0, 1, 0, 0, 0);

      for (int i = 0; i < 3000; i++) begin
         cyc(($urandom % 200) == 0, ($urandom % 4) == 0, ($urandom % 8) == 0,
             ($urandom % 40) == 0, ($urandom % 6) == 0);
      end
      repeat (2) cyc(0, 0, 0, 0, 0);

      @(negedge clk);
      #1;
      check("drain_exp", 32'(exp_q0.size() + exp_q1.size()), 32'd0);
      check("drain_lap", 32'(lap_q0.size() + lap_q1.size()), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
Parametrised run/pause/stop controller with an integrated prescaled event counter, lap capture and terminal-count handling. It is the multi-mode successor of the single-bit start/stop count-enable FSM, and sits between user/debounced control pulses and the display or readout logic. It owns both the control state and the count value, so downstream logic only consumes registered outputs.

Parameters:
W, 16, width of count and lap_count
PRESCALE, 1, clk cycles per count increment while running; legal range 1..65535
MAX_COUNT, 2**16-1, terminal count; must be less than or equal to 2**W-1
WRAP, 0, 0 = saturate at MAX_COUNT and enter DONE; 1 = roll over to 0 and keep running

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous, active-high reset
start  in  1  start/resume request, sampled every cycle
stop  in  1  pause request
clear  in  1  return to IDLE and zero the count
lap  in  1  capture the current count
count  out  W  current count, registered
lap_count  out  W  last captured count, registered
lap_valid  out  1  one-cycle pulse, coincident with a lap_count update
running  out  1  high in RUN
done  out  1  high in DONE (WRAP=0 only)
tick  out  1  one-cycle pulse, coincident with each count update
wrap  out  1  one-cycle pulse when count rolls MAX_COUNT->0 (WRAP=1)

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst. All state and outputs are registered.
- Reset (any state, mid-operation): state=IDLE, count=0, lap_count=0, prescaler=0, all pulses and flags 0 on the next edge.
- Command priority per cycle: rst > clear > stop > start. lap is independent of the commands but is blocked by rst/clear.
- States: IDLE, RUN, PAUSE, DONE.
- IDLE: start -> RUN. stop has no effect. start+stop together -> stay IDLE.
- RUN: stop -> PAUSE, with no increment that cycle even if the prescaler is terminal. clear -> IDLE. start has no effect.
- PAUSE: start -> RUN (resume). count and prescaler are held, not reset. clear -> IDLE.
- DONE: only clear or rst leave DONE. start, stop and lap are ignored.
- clear (any state): next edge gives IDLE, count=0, prescaler=0, lap_count=0.
- Prescaler counts 0..PRESCALE-1 only in RUN cycles without stop/clear.
- Terminal cycle (prescaler==PRESCALE-1): prescaler->0 and count updates at that edge. tick=1 for the following cycle, aligned with the new count.
- PRESCALE=1: count updates on every RUN cycle.
- First increment after start from IDLE: PRESCALE cycles after running rises.
- Count update at terminal:
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT, WRAP=1: count->0, wrap=1 with tick, state stays RUN.
  - count==MAX_COUNT, WRAP=0: no change to count.
- Saturating path (WRAP=0): the increment that makes count==MAX_COUNT also moves the state to DONE at the same edge. running=0 and done=1 from the next cycle.
- Lap: lap in RUN or PAUSE captures the count value visible in that cycle, i.e. the pre-increment value if an increment coincides. lap_count updates at that edge, and lap_valid=1 for exactly the following cycle.
- Lap in IDLE or DONE is ignored.
- Held levels: start held in RUN is harmless. start held across rst deassertion -> IDLE for one cycle, then RUN.
- Flags: running = (state==RUN); done = (state==DONE). Both are registered state decodes.
- Arithmetic: all count arithmetic is unsigned W bits. The prescaler width is clog2(PRESCALE), minimum 1.

Test Plan:
- W=8, PRESCALE=4, MAX_COUNT=9, WRAP=0: one-cycle start -> running=1 next cycle; count 0->1 four cycles later; tick pulses every 4th cycle thereafter.
- Same config: stop when count=3 and prescaler=2 -> PAUSE; count stays 3 for 20 cycles; start -> count=4 exactly 2 RUN cycles after resume.
- Same config: run to the 9th increment -> count=9, done=1, running=0; start and lap ignored for 10 cycles; clear -> count=0, done=0, IDLE.
- WRAP=1, MAX_COUNT=9: increment from count=9 -> count=0, tick=1 and wrap=1 in the same cycle, running stays 1.
- lap in the same cycle as the 4->5 increment -> lap_count=4, lap_valid high one cycle, count=5. Also start+stop together in IDLE -> stays IDLE.
- rst asserted mid-RUN (count=6) with start held high -> next cycle all outputs 0 in IDLE; after rst drops -> RUN the cycle after.
